// File: rtl/univ_shift_reg_if.sv
// Request/response bundle for the universal shift register.
// Master drives requests and serial inputs; slave returns state.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
);
    logic             en;
    logic             op_valid;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] pdata;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output en, op_valid, op, amt,
        output sin_l, sin_r, pdata,
        input  q, sout_l, sout_r,
        input  busy, done
    );

    modport slave (
        input  en, op_valid, op, amt,
        input  sin_l, sin_r, pdata,
        output q, sout_l, sout_r,
        output busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: load, clear, shifts and rotates.
// Multi-step ops run one bit per enabled cycle under busy/done.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic clr,
    univ_shift_reg_if.slave bus
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_SHL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_ROL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_LOAD = 3'b101,
        OP_ASR  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [AMT_W-1:0] WMAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] ONE  = AMT_W'(1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    op_e              req_op;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [AMT_W-1:0] amt_c;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] step_d;
    logic             done_q, done_d;

    assign req_op = op_e'(bus.op);
    assign amt_c  = (bus.amt > WMAX) ? WMAX : bus.amt;

    // One single-bit step of the latched operation.
    always_comb begin
        step_d = q_q;
        unique case (op_q)
            OP_SHL:  step_d = {q_q[WIDTH-2:0], bus.sin_l};
            OP_SHR:  step_d = {bus.sin_r, q_q[WIDTH-1:1]};
            OP_ROL:  step_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            OP_ROR:  step_d = {q_q[0], q_q[WIDTH-1:1]};
            OP_ASR:  step_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            default: step_d = q_q;
        endcase
    end

    // Next-state: accept in IDLE, step while enabled in RUN.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    unique case (req_op)
                        OP_NOP: begin
                            done_d = 1'b1;
                        end
                        OP_LOAD: begin
                            q_d    = bus.pdata;
                            done_d = 1'b1;
                        end
                        OP_CLR: begin
                            q_d    = '0;
                            done_d = 1'b1;
                        end
                        default: begin
                            op_d  = req_op;
                            cnt_d = amt_c;
                            if (amt_c == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = RUN;
                            end
                        end
                    endcase
                end
            end
            RUN: begin
                if (bus.en) begin
                    q_d   = step_d;
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d = IDLE;
                        op_d    = OP_NOP;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; clr aborts any op without a done pulse.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign bus.q      = q_q;
    assign bus.sout_l = q_q[WIDTH-1];
    assign bus.sout_r = q_q[0];
    assign bus.busy   = (state_q == RUN);
    assign bus.done   = done_q;

endmodule
